router_in_arb: RTL and testbench
================================

Name: router_in_arb

Overview:
- Packet-granular round-robin arbiter that shares the single 1x3 router input port (pkt_valid/data_in/busy) between NUM_SRC upstream sources.
- Sits in front of the router top. It grants one source per packet and passes that source's bytes through to the router, stalling on router busy.
- It frames pkt_valid per the router protocol:
  - pkt_valid is high for the header and payload bytes.
  - pkt_valid is low for the parity byte.
  - There is a mandatory 1-cycle gap between packets.

Parameters:
- NUM_SRC, 4, number of upstream requesters (2..8).
- DATA_W, 8, byte width. The header layout assumes 8: len = [7:2], dest addr = [1:0].
- SRC_W, 2, width of grant_id; must be at least clog2(NUM_SRC).

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- src_valid  in  NUM_SRC  source i presents a valid byte on its data lane
- src_data  in  NUM_SRC*DATA_W  source data lanes; lane i = [i*DATA_W +: DATA_W]
- src_ready  out  NUM_SRC  one-hot; byte accepted from source i when src_valid[i] & src_ready[i]
- busy  in  1  router input stall; no byte is accepted while high
- pkt_valid  out  1  to router
- data_in  out  DATA_W  to router
- grant_id  out  SRC_W  index of the current or last granted source
- arb_active  out  1  a packet is in progress
- err_abort  out  1  1-cycle pulse when the granted source drops src_valid mid-packet

Behaviour:
- Reset (async, resetn=0) values:
  - src_ready=0, pkt_valid=0, data_in=0, grant_id=0, arb_active=0, err_abort=0.
  - state=IDLE, rr pointer=NUM_SRC-1, so source 0 has first priority.
- Registered FSM with states IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - If any src_valid is high, pick the first requester searching upward from ptr+1 with wrap.
  - Register grant_id, update ptr to the granted index, set arb_active=1, then go to HEADER.
  - Grant latency is 1 cycle after request.
- Datapath (all states except IDLE and GAP):
  - data_in = lane[grant_id] (combinational mux); otherwise data_in=0.
  - src_ready[grant_id] = ~busy & src_valid[grant_id].
  - xfer = src_valid[g] & ~busy.
- HEADER:
  - pkt_valid = src_valid[g].
  - On xfer, load the 6-bit count rem = data[7:2].
  - If rem==0, go to PARITY; else go to PAYLOAD.
- PAYLOAD:
  - pkt_valid = src_valid[g].
  - On xfer, decrement rem; when rem reaches 1 and is accepted, go to PARITY.
  - Number of payload bytes equals the header length exactly.
- PARITY:
  - pkt_valid=0 and data_in = lane[g].
  - On xfer, clear arb_active and go to GAP.
- GAP:
  - One cycle with all outputs idle, then go to IDLE.
  - Guarantees pkt_valid low for at least 1 cycle between packets.
- busy high in any active state:
  - Holds the state and rem, and src_ready=0.
  - pkt_valid and data_in keep following the granted source, which is required to hold its byte.
- Abort: src_valid[g]=0 while busy=0 in HEADER, PAYLOAD or PARITY:
  - Pulse err_abort for 1 cycle, go to GAP, set arb_active=0.
  - The ptr advance is kept.
  - The router receives a truncated packet; recovery is by the router soft reset.
- While busy=1, src_valid is not checked for abort.
- Requests from non-granted sources are ignored until IDLE. A source requesting at the end of GAP competes in the same cycle.
- Fairness: with N continuously requesting sources, each gets exactly one packet per N packets.
- Reset mid-packet: immediate return to the reset values. No packet is resumed.

Decomposition:
- router_pkg holds:
  - The state enum (IDLE/HEADER/PAYLOAD/PARITY/GAP).
  - Header field constants: LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0.
  - LEN_W=6.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_SRC], ptr.
  - Outputs: gnt_idx, any_req.
  - Reusable elsewhere in the router.

Test Plan:
- Single packet:
  - Stimulus: src0 sends header 8'h0D (len 3, addr 01), payload AA BB CC, parity, busy=0.
  - Response: grant_id=0 one cycle after request; pkt_valid high for 4 cycles, then low on the parity byte; arb_active drops; 1 gap cycle.
- Contention:
  - Stimulus: src0..3 all request continuously with len-1 packets.
  - Response: grant order 0,1,2,3,0; every packet is contiguous on data_in and each is followed by a gap cycle.
- Busy stall:
  - Stimulus: busy=1 for 3 cycles during the second payload byte.
  - Response: src_ready=0, data_in held and rem unchanged for those cycles; packet completes with the correct byte count.
- Zero length:
  - Stimulus: header 8'h02.
  - Response: HEADER goes directly to PARITY; pkt_valid high for exactly 1 byte.
- Abort:
  - Stimulus: src2 drops src_valid after 1 of 5 payload bytes with busy=0.
  - Response: err_abort=1 for one cycle, pkt_valid=0; the next grant goes to source 3.
- Reset:
  - Stimulus: resetn low mid-PAYLOAD.
  - Response: all outputs 0 immediately; after release, src0 wins first.

Source files
------------

// File: rtl/router_in_arb_pkg.sv
// Shared FSM state type and header field positions for the router input arbiter.
// No logic here, so no latency.
// No flow control here; the types are used by the arbiter and its picker.
package router_in_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      PARITY,
      GAP
   } state_e;

   // Header byte layout: length in the upper six bits, destination in the lower two.
   localparam int LEN_MSB  = 7;
   localparam int LEN_LSB  = 2;
   localparam int ADDR_MSB = 1;
   localparam int ADDR_LSB = 0;
   localparam int LEN_W    = 6;

   localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

endpackage

// File: rtl/router_in_arb_if.sv
// Bundle of source lanes, router input handshake and arbiter status.
// Wires only, no latency.
// Sources hold their byte until src_valid & src_ready; busy stalls the router side.
interface router_in_arb_if #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 8,
   parameter int SRC_W   = 2
);
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_ready;
   logic                      busy;
   logic                      pkt_valid;
   logic [DATA_W-1:0]         data_in;
   logic [SRC_W-1:0]          grant_id;
   logic                      arb_active;
   logic                      err_abort;

   // Source/router side: drives requests and stall, observes the arbiter.
   modport master (
      output src_valid, src_data, busy,
      input  src_ready, pkt_valid, data_in, grant_id, arb_active, err_abort
   );

   // Arbiter side.
   modport slave (
      input  src_valid, src_data, busy,
      output src_ready, pkt_valid, data_in, grant_id, arb_active, err_abort
   );
endinterface

// File: rtl/router_in_arb_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping to index 0.
// Purely combinational, zero latency.
// No flow control; the caller decides when to consume the pick.
module rr_pick #(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic [SRC_W-1:0]   gnt_idx,
   output logic               any_req
);
   logic             hi_hit;
   logic             lo_hit;
   logic [SRC_W-1:0] hi_idx;
   logic [SRC_W-1:0] lo_idx;

   // Lowest requester above ptr wins; otherwise lowest at or below ptr (the wrap).
   always_comb begin
      hi_hit = 1'b0;
      lo_hit = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (SRC_W'(i) > ptr) begin
               hi_hit = 1'b1;
               hi_idx = SRC_W'(i);
            end else begin
               lo_hit = 1'b1;
               lo_idx = SRC_W'(i);
            end
         end
      end
      any_req = hi_hit | lo_hit;
      gnt_idx = hi_hit ? hi_idx : lo_idx;
   end
endmodule

// File: rtl/router_in_arb.sv
// Packet-granular round-robin arbiter feeding the single router input port.
// Grant 1 cycle after request; bytes pass combinationally from the granted lane.
// busy freezes the packet and deasserts src_ready; granted source must hold its byte.
module router_in_arb
   import router_in_arb_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 8,
   parameter int SRC_W   = 2
) (
   input logic             clock,
   input logic             resetn,
   router_in_arb_if.slave  bus
);
   state_e            state_q, state_d;
   logic [SRC_W-1:0]  grant_q, grant_d;
   logic [SRC_W-1:0]  ptr_q, ptr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              arb_active_q, arb_active_d;
   logic              err_abort_q, err_abort_d;

   logic [DATA_W-1:0] lane_g;
   logic              vld_g;
   logic              xfer;
   logic [SRC_W-1:0]  pick_idx;
   logic              pick_any;

   rr_pick #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_pick (
      .req     (bus.src_valid),
      .ptr     (ptr_q),
      .gnt_idx (pick_idx),
      .any_req (pick_any)
   );

   // Mux out the granted source's byte and valid.
   always_comb begin
      lane_g = '0;
      vld_g  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q == SRC_W'(i)) begin
            lane_g = bus.src_data[i*DATA_W +: DATA_W];
            vld_g  = bus.src_valid[i];
         end
      end
   end

   // Packet framing FSM: next state, byte counter and router-facing outputs.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      ptr_d         = ptr_q;
      rem_d         = rem_q;
      arb_active_d  = arb_active_q;
      err_abort_d   = 1'b0;
      bus.src_ready = '0;
      bus.pkt_valid = 1'b0;
      bus.data_in   = '0;
      xfer          = vld_g & ~bus.busy;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d      = pick_idx;
               ptr_d        = pick_idx;
               arb_active_d = 1'b1;
               state_d      = HEADER;
            end
         end
         HEADER, PAYLOAD, PARITY: begin
            bus.data_in   = lane_g;
            bus.pkt_valid = vld_g & (state_q != PARITY);
            for (int i = 0; i < NUM_SRC; i++) begin
               if (grant_q == SRC_W'(i)) bus.src_ready[i] = xfer;
            end
            // Valid is only judged while the router can take the byte.
            if (!bus.busy) begin
               if (!vld_g) begin
                  err_abort_d  = 1'b1;
                  arb_active_d = 1'b0;
                  state_d      = GAP;
               end else begin
                  case (state_q)
                     HEADER: begin
                        rem_d   = lane_g[LEN_MSB:LEN_LSB];
                        state_d = (rem_d == '0) ? PARITY : PAYLOAD;
                     end
                     PAYLOAD: begin
                        rem_d = rem_q - REM_ONE;
                        if (rem_q == REM_ONE) state_d = PARITY;
                     end
                     default: begin
                        arb_active_d = 1'b0;
                        state_d      = GAP;
                     end
                  endcase
               end
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and grant registers; reset points ptr at the last source so source 0 leads.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         ptr_q        <= SRC_W'(NUM_SRC - 1);
         rem_q        <= '0;
         arb_active_q <= 1'b0;
         err_abort_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         ptr_q        <= ptr_d;
         rem_q        <= rem_d;
         arb_active_q <= arb_active_d;
         err_abort_q  <= err_abort_d;
      end
   end

   assign bus.grant_id   = grant_q;
   assign bus.arb_active = arb_active_q;
   assign bus.err_abort  = err_abort_q;

endmodule

// File: tb/tb_router_in_arb.sv
// Bench for router_in_arb: randomized sources checked every cycle against a packet-level model.
// Model tracks bytes accepted per packet rather than FSM states.
// Directed traces pin single packet, contention order, zero length, busy stall, abort and reset.
module tb_router_in_arb;
   localparam int NUM_SRC = 4;
   localparam int DATA_W  = 8;
   localparam int SRC_W   = 2;
   localparam int TR_MAX  = 64;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   router_in_arb_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SRC_W(SRC_W)) bus ();

   router_in_arb #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Source byte streams and stimulus controls
   logic [7:0]         sq [NUM_SRC][$];
   logic [NUM_SRC-1:0] acc   = '0;
   logic [NUM_SRC-1:0] pause = '0;
   int                 busy_pct = 0;
   bit                 pause_en = 1'b0;
   bit                 busy_sched [$];

   // Packet-level reference model
   bit m_active, m_gap, m_abort;
   int m_g, m_ptr, m_len, m_cnt;

   // Output traces and grant log
   logic [31:0] tr_pv [TR_MAX];
   logic [31:0] tr_d  [TR_MAX];
   logic [31:0] tr_act[TR_MAX];
   logic [31:0] tr_err[TR_MAX];
   logic [31:0] tr_rdy[TR_MAX];
   logic [31:0] tr_gid[TR_MAX];
   int          tr_n = 0;
   int          gnt_log [$];
   bit          prev_act = 1'b0;

   // Hand-derived expectations (bit k = trace cycle k)
   logic [7:0]  sgl_d [8]  = '{8'h00, 8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'h5A, 8'h00, 8'h00};
   logic [7:0]  sgl_pv     = 8'b0001_1110;
   logic [7:0]  sgl_act    = 8'b0011_1110;
   logic [7:0]  sgl_rdy    = 8'b0011_1110;
   logic [7:0]  zl_d [5]   = '{8'h00, 8'h02, 8'h77, 8'h00, 8'h00};
   logic [4:0]  zl_pv      = 5'b00010;
   logic [4:0]  zl_act     = 5'b00110;
   logic [7:0]  bs_d [10]  = '{8'h00, 8'h0C, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h00};
   logic [9:0]  bs_pv      = 10'b00_1111_1110;
   logic [9:0]  bs_rdy     = 10'b01_1100_0110;
   logic [8:0]  ab_pv      = 9'b0_0100_0110;
   logic [8:0]  ab_err     = 9'b0_0001_0000;
   logic [8:0]  ab_act     = 9'b0_1100_1110;
   int          cont_ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_bound(input string nm, input bit expired);
      n_cmp++;
      if (expired) begin
         n_bad++;
         $display("FAIL %s: cycle budget expired", nm);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0; m_gap = 1'b0; m_abort = 1'b0;
      m_g = 0; m_ptr = NUM_SRC - 1; m_len = 0; m_cnt = 0;
      prev_act = 1'b0;
   endtask

   task automatic apply();
      for (int i = 0; i < NUM_SRC; i++) begin
         bus.src_valid[i] = (sq[i].size() > 0) && !pause[i];
         bus.src_data[i*DATA_W +: DATA_W] = (sq[i].size() > 0) ? sq[i][0] : 8'h00;
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_SRC; i++)
         if (acc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
      acc = '0;
      if (busy_sched.size() > 0) bus.busy = busy_sched.pop_front();
      else                       bus.busy = ($urandom_range(0, 99) < busy_pct);
      for (int i = 0; i < NUM_SRC; i++)
         pause[i] = pause_en && ($urandom_range(0, 31) == 0);
      apply();
   endtask

   // Compare DUT outputs with the model for this cycle, then advance the model.
   task automatic check_and_advance();
      logic [NUM_SRC-1:0] v, e_rdy;
      logic [7:0]         lane, e_d;
      logic               vg, e_pv, par, found;
      v     = bus.src_valid;
      lane  = 8'(bus.src_data >> (m_g * DATA_W));
      vg    = v[m_g];
      e_rdy = '0; e_pv = 1'b0; e_d = 8'h00;
      if (m_active) begin
         par  = (m_cnt == m_len + 1);
         e_d  = lane;
         e_pv = vg && !par;
         if (vg && !bus.busy) e_rdy[m_g] = 1'b1;
      end
      chk("src_ready",  32'(bus.src_ready),  32'(e_rdy));
      chk("pkt_valid",  32'(bus.pkt_valid),  32'(e_pv));
      chk("data_in",    32'(bus.data_in),    32'(e_d));
      chk("grant_id",   32'(bus.grant_id),   32'(m_g));
      chk("arb_active", 32'(bus.arb_active), 32'(m_active));
      chk("err_abort",  32'(bus.err_abort),  32'(m_abort));
      if (tr_n < TR_MAX) begin
         tr_pv[tr_n]  = 32'(bus.pkt_valid);
         tr_d[tr_n]   = 32'(bus.data_in);
         tr_act[tr_n] = 32'(bus.arb_active);
         tr_err[tr_n] = 32'(bus.err_abort);
         tr_rdy[tr_n] = 32'(bus.src_ready);
         tr_gid[tr_n] = 32'(bus.grant_id);
         tr_n++;
      end
      acc = bus.src_valid & bus.src_ready;
      if (bus.arb_active && !prev_act) gnt_log.push_back(int'(bus.grant_id));
      prev_act = bus.arb_active;

      m_abort = 1'b0;
      if (m_gap) begin
         m_gap = 1'b0;
      end else if (!m_active) begin
         found = 1'b0;
         for (int k = 1; k <= NUM_SRC; k++) begin
            if (!found && v[(m_ptr + k) % NUM_SRC]) begin
               found    = 1'b1;
               m_g      = (m_ptr + k) % NUM_SRC;
               m_ptr    = m_g;
               m_active = 1'b1;
               m_cnt    = 0;
            end
         end
      end else if (!bus.busy) begin
         if (!vg) begin
            m_abort = 1'b1; m_active = 1'b0; m_gap = 1'b1;
         end else if (m_cnt == 0) begin
            m_len = int'(lane[7:2]);
            m_cnt = 1;
         end else if (m_cnt == m_len + 1) begin
            m_active = 1'b0; m_gap = 1'b1;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clock);
      check_and_advance();
      @(posedge clock);
      #1;
      drive();
   endtask

   function automatic bit all_quiet();
      bit q = !m_active && !m_gap && !m_abort;
      for (int i = 0; i < NUM_SRC; i++) if (sq[i].size() > 0) q = 1'b0;
      return q;
   endfunction

   task automatic wait_idle(input string nm, input int budget);
      int n = 0;
      while (!all_quiet() && n < budget) begin
         cycle();
         n++;
      end
      chk_bound(nm, n >= budget);
      repeat (2) cycle();
   endtask

   task automatic start_trace();
      tr_n = 0;
      gnt_log.delete();
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, " src_ready"},  32'(bus.src_ready),  32'h0);
      chk({nm, " pkt_valid"},  32'(bus.pkt_valid),  32'h0);
      chk({nm, " data_in"},    32'(bus.data_in),    32'h0);
      chk({nm, " grant_id"},   32'(bus.grant_id),   32'h0);
      chk({nm, " arb_active"}, 32'(bus.arb_active), 32'h0);
      chk({nm, " err_abort"},  32'(bus.err_abort),  32'h0);
   endtask

   initial begin
      int n;
      logic [5:0] len;
      bus.src_valid = '0;
      bus.src_data  = '0;
      bus.busy      = 1'b0;
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;

      // Contention: all four sources, two length-1 packets each
      start_trace();
      for (int i = 0; i < NUM_SRC; i++)
         for (int p = 0; p < 2; p++) begin
            sq[i].push_back(8'h04 | 8'(i));
            sq[i].push_back(8'(16 * i + p));
            sq[i].push_back(8'hE0 | 8'(i));
         end
      apply();
      wait_idle("contention drain", 200);
      chk("contention grants", 32'(gnt_log.size()), 32'd8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("contention order[%0d]", k),
             (k < gnt_log.size()) ? 32'(gnt_log[k]) : 32'hFFFF, 32'(cont_ord[k]));

      // Single packet from source 0
      start_trace();
      sq[0] = '{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'h5A};
      apply();
      repeat (8) cycle();
      chk("single grant_id", tr_gid[1], 32'd0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("single data[%0d]", k), tr_d[k],   32'(sgl_d[k]));
         chk($sformatf("single pv[%0d]", k),   tr_pv[k],  32'(sgl_pv[k]));
         chk($sformatf("single act[%0d]", k),  tr_act[k], 32'(sgl_act[k]));
         chk($sformatf("single rdy[%0d]", k),  tr_rdy[k], 32'(sgl_rdy[k]));
      end

      // Zero-length packet from source 1
      start_trace();
      sq[1] = '{8'h02, 8'h77};
      apply();
      repeat (5) cycle();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("zero data[%0d]", k), tr_d[k],   32'(zl_d[k]));
         chk($sformatf("zero pv[%0d]", k),   tr_pv[k],  32'(zl_pv[k]));
         chk($sformatf("zero act[%0d]", k),  tr_act[k], 32'(zl_act[k]));
      end

      // Busy for 3 cycles on the second payload byte
      start_trace();
      sq[0] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
      busy_sched = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      apply();
      repeat (10) cycle();
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("busy data[%0d]", k), tr_d[k],   32'(bs_d[k]));
         chk($sformatf("busy pv[%0d]", k),   tr_pv[k],  32'(bs_pv[k]));
         chk($sformatf("busy rdy[%0d]", k),  tr_rdy[k], 32'(bs_rdy[k]));
      end

      // Abort: source 2 stops after one of five payload bytes; source 3 waiting
      start_trace();
      sq[2] = '{8'h16, 8'hE1};
      sq[3] = '{8'h03, 8'h99};
      apply();
      repeat (9) cycle();
      chk("abort first grant", tr_gid[1], 32'd2);
      chk("abort next grant",  tr_gid[6], 32'd3);
      chk("abort src3 header", tr_d[6],   32'h03);
      chk("abort src3 parity", tr_d[7],   32'h99);
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("abort pv[%0d]", k),  tr_pv[k],  32'(ab_pv[k]));
         chk($sformatf("abort err[%0d]", k), tr_err[k], 32'(ab_err[k]));
         chk($sformatf("abort act[%0d]", k), tr_act[k], 32'(ab_act[k]));
      end

      // Randomized traffic with busy and source pauses
      for (int i = 0; i < NUM_SRC; i++)
         for (int p = 0; p < 5; p++) begin
            len = 6'($urandom_range(0, 6));
            sq[i].push_back({len, 2'($urandom_range(0, 2))});
            for (int b = 0; b < int'(len); b++) sq[i].push_back(8'($urandom));
            sq[i].push_back(8'($urandom));
         end
      busy_pct = 25;
      pause_en = 1'b1;
      apply();
      wait_idle("random drain", 20000);
      busy_pct = 0;
      pause_en = 1'b0;
      pause    = '0;
      repeat (2) cycle();

      // Reset in the middle of a payload
      sq[0] = '{8'h14, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      apply();
      n = 0;
      while (!(m_active && m_cnt == 3) && n < 20) begin
         cycle();
         n++;
      end
      chk_bound("reach mid payload", n >= 20);
      #2;
      resetn = 1'b0;
      #1;
      check_reset_outputs("mid-packet reset");
      model_reset();
      for (int i = 0; i < NUM_SRC; i++) sq[i].delete();
      acc = '0;
      apply();
      @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      start_trace();
      for (int i = 0; i < NUM_SRC; i++) begin
         sq[i].push_back(8'h00 | 8'(i));
         sq[i].push_back(8'hC0 | 8'(i));
      end
      apply();
      wait_idle("post-reset drain", 200);
      chk("post-reset first grant", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF, 32'd0);
      chk("post-reset second grant", (gnt_log.size() > 1) ? 32'(gnt_log[1]) : 32'hFFFF, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
